mfp_adc_max10_seq: RTL and testbench
====================================

# mfp_adc_max10_seq

Parametrised successor to the MAX10 ADC register/sequencer core. It converts a CPU-visible register file into Avalon-ST command packets for the Altera MAX10 ADC hard block and captures the response samples. Over the fixed 7-channel core it adds:
- a configurable channel count and channel map;
- continuous scan mode with a mask snapshot per sequence;
- edge-detected trigger and self-clearing start;
- per-channel new-data and overrun flags.

It sits between the AHB-Lite register bridge and the ADC IP.

## Interface
- CH_COUNT, 7: number of sample cells, legal range 1..16.
- DATA_WIDTH, 12: sample width, ≤ 32.
- ADDR_WIDTH, 4: register address width. Requires 2^ADDR_WIDTH ≥ 4 + CH_COUNT.
- CH_MAP, {5'd17,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1}: packed 5·CH_COUNT bits. Cell i maps to ADC channel CH_MAP[5i+4:5i].
- Clocking (already decided): one clock; reset is asynchronous and active-low.
- CLK  in  1  clock.
- RESETn  in  1  asynchronous active-low reset.
- read_addr  in  ADDR_WIDTH  register read address.
- read_data  out  32  combinational read data.
- write_addr  in  ADDR_WIDTH  register write address.
- write_data  in  32  register write data.
- write_enable  in  1  register write strobe.
- ADC_C_Valid / ADC_C_Channel[4:0] / ADC_C_SOP / ADC_C_EOP  out  command stream, all registered.
- ADC_C_Ready  in  1  command accept.
- ADC_R_Valid / ADC_R_Channel[4:0] / ADC_R_Data[11:0] / ADC_R_SOP / ADC_R_EOP  in  response stream.
- ADC_Trigger  in  1  external trigger, rising-edge sensitive.
- ADC_Interrupt  out  1  equals ADCS.IF.

## Operation
Register map:
- 0 ADCS, bits:
  - 0 EN
  - 1 SC
  - 2 TE
  - 3 IE
  - 4 IF (W1C)
  - 5 CONT
  - 6 BUSY (read-only)
- 1 ADMSK[CH_COUNT-1:0]: cell enable mask.
- 2 ADNEW: W1C new-data flags.
- 3 ADOVR: W1C overrun flags.
- 4+i: sample of cell i, zero-extended.
- Unmapped addresses read 0; writes to them are ignored.

ADCS write behaviour:
- EN, SC, TE, IE and CONT load from write_data.
- Writing IF=1 clears IF.

FSM states:
- IDLE → ISSUE when `EN & (ADMSK≠0) & (SC | (TE & trig_rise))`.
  - trig_rise = ADC_Trigger & ~ADC_Trigger_q.
  - On this transition the FSM snapshots ADMSK into `smask`, selects the lowest set cell, and clears SC.
  - A CPU write to ADCS in the same cycle wins for SC.
- ISSUE holds the command stable until `ADC_C_Valid & ADC_C_Ready`.
  - Cells are issued in ascending index order over `smask`.
  - SOP is set on the first command of a sequence; EOP is set on the last (the cell with no higher set bit).
  - A single-cell sequence asserts SOP and EOP together.
- After the last command is accepted:
  - if `CONT & EN & ADMSK≠0`, a new sequence starts: re-snapshot, SOP again;
  - otherwise the FSM returns to IDLE.
- Trigger edges or SC while in ISSUE are ignored. SC stays set and starts a sequence once the FSM is back in IDLE.
- Clearing EN mid-sequence does not abort. The sequence runs through EOP, then the FSM goes to IDLE.
- ADMSK writes mid-sequence affect only the next sequence.

Response capture:
- For each cell i, when `ADC_R_Valid & ADC_R_Channel==CH_MAP[i]`:
  - data[i] ← ADC_R_Data[DATA_WIDTH-1:0], zero-padded if DATA_WIDTH > 12;
  - NEW[i] ← 1;
  - if NEW[i] was already 1, OVR[i] ← 1.
- Duplicate map entries update every matching cell.
- IF is set on `ADC_R_Valid & ADC_R_EOP & IE`.
- On any W1C flag, a hardware set in the same cycle wins over the CPU clear.

## Timing
- Reset values:
  - all registers and flags 0;
  - ADC_C_Valid, SOP and EOP 0;
  - ADC_C_Channel 0;
  - ADC_Interrupt 0;
  - FSM in IDLE.
- Reset mid-sequence drops ADC_C_Valid immediately (asynchronously). No EOP is issued.
- Start latency: a start condition in cycle N gives ADC_C_Valid=1 in N+1.
  - A write setting SC in cycle N is visible as the start condition in N+1, so Valid rises in N+2.
- Back-to-back issue: a command accepted in cycle M presents the next command in M+1. There are no bubbles, including across continuous-mode sequence boundaries.
- After the last accept in M with no restart, ADC_C_Valid=0 and BUSY=0 in M+1.
- Captured data, NEW, OVR and IF are visible on read_data in the cycle after the response beat.
- read_data is combinational from registers, so there is zero-cycle read latency.

## Test plan
- Mask bits 0, 2 and 3 in ADMSK, then write ADCS=0x3:
  - three commands in order: channels 1 (SOP), 3, 4 (EOP);
  - SC reads 0 after the start;
  - IDLE and BUSY=0 after the last accept.
- ADC_C_Ready held low for 5 cycles on the 2nd command → command fields stay stable until accepted; no duplicate or skipped channel.
- Mask 0x40, TE=1, IE=1, EN=1, ADC_Trigger held high for 10 cycles:
  - exactly one command, channel 17, with SOP=EOP=1;
  - response EOP with data 0xABC → cell 6 reads 0xABC, NEW bit 6 set, ADC_Interrupt=1;
  - writing ADCS with IF=1 clears the interrupt.
- CONT=1, mask 0x3:
  - continuous SOP/EOP pairs with no idle cycles;
  - clear EN mid-sequence → the current sequence finishes with EOP, then IDLE.
- Two responses on channel 2 without clearing ADNEW → OVR bit 1 set. Then W1C ADNEW in the same cycle as a new channel-2 response → NEW stays 1.
- Assert RESETn=0 during ISSUE → all outputs 0 without waiting for a clock edge; registers read 0.

Source files
------------

// File: rtl/mfp_adc_max10_seq_if.sv
// Bundle of CPU register port and Avalon-ST command/response streams for the MAX10 ADC sequencer.
// The slave view belongs to the sequencer; the master view belongs to whoever drives it.
interface mfp_adc_max10_seq_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [31:0]           read_data;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [31:0]           write_data;
    logic                  write_enable;

    logic                  ADC_C_Valid;
    logic [4:0]            ADC_C_Channel;
    logic                  ADC_C_SOP;
    logic                  ADC_C_EOP;
    logic                  ADC_C_Ready;

    logic                  ADC_R_Valid;
    logic [4:0]            ADC_R_Channel;
    logic [11:0]           ADC_R_Data;
    logic                  ADC_R_SOP;
    logic                  ADC_R_EOP;

    logic                  ADC_Trigger;
    logic                  ADC_Interrupt;

    modport slave (
        input  read_addr, write_addr, write_data, write_enable,
        input  ADC_C_Ready,
        input  ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP,
        input  ADC_Trigger,
        output read_data,
        output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
        output ADC_Interrupt
    );

    modport master (
        output read_addr, write_addr, write_data, write_enable,
        output ADC_C_Ready,
        output ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP,
        output ADC_Trigger,
        input  read_data,
        input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
        input  ADC_Interrupt
    );
endinterface

// File: rtl/mfp_adc_max10_seq.sv
// MAX10 ADC register file and sequencer: issues Avalon-ST channel commands over a
// snapshotted cell mask and captures response samples with new-data/overrun flags.
module mfp_adc_max10_seq #(
    parameter int                    CH_COUNT   = 7,
    parameter int                    DATA_WIDTH = 12,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [5*CH_COUNT-1:0] CH_MAP     = {5'd17, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}
) (
    input  logic                CLK,
    input  logic                RESETn,
    mfp_adc_max10_seq_if.slave  bus
);
    localparam logic [4:0] NONE = 5'd31;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                r_state, w_state_next;
    logic                  r_en, r_sc, r_te, r_ie, r_if, r_cont;
    logic                  r_trig_q;
    logic [CH_COUNT-1:0]   r_mask, r_smask, w_smask_next;
    logic [CH_COUNT-1:0]   r_new, r_ovr;
    logic [DATA_WIDTH-1:0] r_data [CH_COUNT];
    logic [4:0]            r_cell, w_cell_next;
    logic                  r_c_valid, w_c_valid_next;
    logic [4:0]            r_c_channel, w_c_channel_next;
    logic                  r_c_sop, w_c_sop_next;
    logic                  r_c_eop, w_c_eop_next;
    logic                  w_sc_clr;

    // Lowest set bit of m at index >= lo, or NONE.
    function automatic logic [4:0] first_from(input logic [CH_COUNT-1:0] m, input logic [4:0] lo);
        logic [4:0] idx;
        idx = NONE;
        for (int k = CH_COUNT - 1; k >= 0; k--) begin
            if (m[k] && (5'(k) >= lo)) idx = 5'(k);
        end
        return idx;
    endfunction

    function automatic logic [4:0] map_of(input logic [4:0] c);
        logic [4:0] ch;
        ch = 5'd0;
        for (int k = 0; k < CH_COUNT; k++) begin
            if (c == 5'(k)) ch = CH_MAP[5*k +: 5];
        end
        return ch;
    endfunction

    wire [31:0]           w_raddr    = 32'(bus.read_addr);
    wire [31:0]           w_waddr    = 32'(bus.write_addr);
    wire [31:0]           w_wdata    = bus.write_data;
    wire                  w_wr_adcs  = bus.write_enable && (w_waddr == 32'd0);
    wire                  w_wr_mask  = bus.write_enable && (w_waddr == 32'd1);
    wire                  w_wr_new   = bus.write_enable && (w_waddr == 32'd2);
    wire                  w_wr_ovr   = bus.write_enable && (w_waddr == 32'd3);
    wire [31:0]           w_r_ext    = {20'd0, bus.ADC_R_Data};
    wire [DATA_WIDTH-1:0] w_sample   = w_r_ext[DATA_WIDTH-1:0];
    wire                  w_busy     = (r_state == S_ISSUE);
    wire                  w_trig_rise = bus.ADC_Trigger & ~r_trig_q;
    wire                  w_mask_any = |r_mask;
    wire                  w_start    = r_en && w_mask_any && (r_sc || (r_te && w_trig_rise));
    wire                  w_accept   = r_c_valid && bus.ADC_C_Ready;
    wire [4:0]            w_first    = first_from(r_mask, 5'd0);
    wire                  w_first_last = (first_from(r_mask, w_first + 5'd1) == NONE);
    wire [4:0]            w_next     = first_from(r_smask, r_cell + 5'd1);
    wire                  w_next_last  = (first_from(r_smask, w_next + 5'd1) == NONE);
    wire                  w_if_set   = bus.ADC_R_Valid && bus.ADC_R_EOP && r_ie;
    wire                  w_unused_ok = &{1'b0, bus.ADC_R_SOP, w_r_ext, w_wdata};

    logic [CH_COUNT-1:0] w_hit;
    for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_hit
        assign w_hit[gi] = bus.ADC_R_Valid && (bus.ADC_R_Channel == CH_MAP[5*gi +: 5]);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state     <= S_IDLE;
            r_smask     <= '0;
            r_cell      <= 5'd0;
            r_c_valid   <= 1'b0;
            r_c_channel <= 5'd0;
            r_c_sop     <= 1'b0;
            r_c_eop     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_smask     <= w_smask_next;
            r_cell      <= w_cell_next;
            r_c_valid   <= w_c_valid_next;
            r_c_channel <= w_c_channel_next;
            r_c_sop     <= w_c_sop_next;
            r_c_eop     <= w_c_eop_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_smask_next     = r_smask;
        w_cell_next      = r_cell;
        w_c_valid_next   = r_c_valid;
        w_c_channel_next = r_c_channel;
        w_c_sop_next     = r_c_sop;
        w_c_eop_next     = r_c_eop;
        w_sc_clr         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next     = S_ISSUE;
                    w_smask_next     = r_mask;
                    w_cell_next      = w_first;
                    w_c_valid_next   = 1'b1;
                    w_c_channel_next = map_of(w_first);
                    w_c_sop_next     = 1'b1;
                    w_c_eop_next     = w_first_last;
                    w_sc_clr         = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_accept) begin
                    if (r_c_eop) begin
                        // Continuous mode restarts without a bubble from the live mask.
                        if (r_cont && r_en && w_mask_any) begin
                            w_smask_next     = r_mask;
                            w_cell_next      = w_first;
                            w_c_channel_next = map_of(w_first);
                            w_c_sop_next     = 1'b1;
                            w_c_eop_next     = w_first_last;
                        end else begin
                            w_state_next   = S_IDLE;
                            w_c_valid_next = 1'b0;
                            w_c_sop_next   = 1'b0;
                            w_c_eop_next   = 1'b0;
                        end
                    end else begin
                        w_cell_next      = w_next;
                        w_c_channel_next = map_of(w_next);
                        w_c_sop_next     = 1'b0;
                        w_c_eop_next     = w_next_last;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Hardware sets of W1C flags take priority over a same-cycle CPU clear.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_en     <= 1'b0;
            r_sc     <= 1'b0;
            r_te     <= 1'b0;
            r_ie     <= 1'b0;
            r_if     <= 1'b0;
            r_cont   <= 1'b0;
            r_trig_q <= 1'b0;
            r_mask   <= '0;
            r_new    <= '0;
            r_ovr    <= '0;
            for (int k = 0; k < CH_COUNT; k++) r_data[k] <= '0;
        end else begin
            r_trig_q <= bus.ADC_Trigger;
            if (w_wr_adcs) begin
                r_en   <= w_wdata[0];
                r_sc   <= w_wdata[1];
                r_te   <= w_wdata[2];
                r_ie   <= w_wdata[3];
                r_cont <= w_wdata[5];
            end else if (w_sc_clr) begin
                r_sc <= 1'b0;
            end
            r_if <= w_if_set | (r_if & ~(w_wr_adcs & w_wdata[4]));
            if (w_wr_mask) r_mask <= w_wdata[CH_COUNT-1:0];
            r_new <= w_hit | (r_new & ~(w_wr_new ? w_wdata[CH_COUNT-1:0] : '0));
            r_ovr <= (w_hit & r_new) | (r_ovr & ~(w_wr_ovr ? w_wdata[CH_COUNT-1:0] : '0));
            for (int k = 0; k < CH_COUNT; k++) begin
                if (w_hit[k]) r_data[k] <= w_sample;
            end
        end
    end

    always_comb begin
        bus.read_data = '0;
        if (w_raddr == 32'd0)
            bus.read_data[6:0] = {w_busy, r_cont, r_if, r_ie, r_te, r_sc, r_en};
        else if (w_raddr == 32'd1)
            bus.read_data[CH_COUNT-1:0] = r_mask;
        else if (w_raddr == 32'd2)
            bus.read_data[CH_COUNT-1:0] = r_new;
        else if (w_raddr == 32'd3)
            bus.read_data[CH_COUNT-1:0] = r_ovr;
        for (int k = 0; k < CH_COUNT; k++) begin
            if (w_raddr == 32'(4 + k)) bus.read_data[DATA_WIDTH-1:0] = r_data[k];
        end
    end

    assign bus.ADC_C_Valid   = r_c_valid;
    assign bus.ADC_C_Channel = r_c_channel;
    assign bus.ADC_C_SOP     = r_c_sop;
    assign bus.ADC_C_EOP     = r_c_eop;
    assign bus.ADC_Interrupt = r_if;
endmodule

// File: tb/tb_mfp_adc_max10_seq.sv
// Directed bench for mfp_adc_max10_seq: command scoreboard plus register/flag checks.
module tb_mfp_adc_max10_seq;
    logic CLK = 1'b0;
    logic RESETn;
    always #5 CLK = ~CLK;

    mfp_adc_max10_seq_if #(.ADDR_WIDTH(4)) bus ();

    mfp_adc_max10_seq #(
        .CH_COUNT  (7),
        .DATA_WIDTH(12),
        .ADDR_WIDTH(4),
        .CH_MAP    ({5'd17, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1})
    ) dut (
        .CLK   (CLK),
        .RESETn(RESETn),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0] ch;
        logic       sop;
        logic       eop;
    } cmd_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    cmd_t sb[$];
    cmd_t held;
    logic hold = 1'b0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.write_addr   = a;
        bus.write_data   = d;
        bus.write_enable = 1'b1;
        tick();
        bus.write_enable = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        bus.read_addr = a;
        #1;
        check(tag, bus.read_data, exp);
    endtask

    task automatic resp(input logic [4:0] ch, input logic [11:0] d, input logic eop);
        bus.ADC_R_Valid   = 1'b1;
        bus.ADC_R_Channel = ch;
        bus.ADC_R_Data    = d;
        bus.ADC_R_SOP     = 1'b1;
        bus.ADC_R_EOP     = eop;
        tick();
        bus.ADC_R_Valid   = 1'b0;
    endtask

    task automatic push(input logic [4:0] ch, input logic sop, input logic eop);
        cmd_t c;
        c.ch  = ch;
        c.sop = sop;
        c.eop = eop;
        sb.push_back(c);
    endtask

    // Every accepted command is popped from the scoreboard; stalled commands must hold still.
    always @(negedge CLK) begin
        cmd_t cur;
        cmd_t exp_c;
        cur = {bus.ADC_C_Channel, bus.ADC_C_SOP, bus.ADC_C_EOP};
        if (!RESETn) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                n_tests++;
                assert ({bus.ADC_C_Valid, cur} === {1'b1, held}) else begin
                    n_fail++;
                    $error("FAIL cmd_stable: observed v=%0b ch=%0d sop=%0b eop=%0b expected v=1 ch=%0d sop=%0b eop=%0b",
                           bus.ADC_C_Valid, cur.ch, cur.sop, cur.eop, held.ch, held.sop, held.eop);
                end
            end
            if (bus.ADC_C_Valid && bus.ADC_C_Ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    assert (sb.size() != 0) else begin
                        n_fail++;
                        $error("FAIL cmd_extra: observed ch=%0d sop=%0b eop=%0b expected no command",
                               cur.ch, cur.sop, cur.eop);
                    end
                end else begin
                    exp_c = sb.pop_front();
                    assert (cur === exp_c) else begin
                        n_fail++;
                        $error("FAIL cmd: observed ch=%0d sop=%0b eop=%0b expected ch=%0d sop=%0b eop=%0b",
                               cur.ch, cur.sop, cur.eop, exp_c.ch, exp_c.sop, exp_c.eop);
                    end
                end
            end
            hold = bus.ADC_C_Valid && !bus.ADC_C_Ready;
            held = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETn            = 1'b0;
        bus.read_addr     = '0;
        bus.write_addr    = '0;
        bus.write_data    = '0;
        bus.write_enable  = 1'b0;
        bus.ADC_C_Ready   = 1'b1;
        bus.ADC_R_Valid   = 1'b0;
        bus.ADC_R_Channel = '0;
        bus.ADC_R_Data    = '0;
        bus.ADC_R_SOP     = 1'b0;
        bus.ADC_R_EOP     = 1'b0;
        bus.ADC_Trigger   = 1'b0;
        tick();
        tick();
        check("rst_cmd", {27'd0, bus.ADC_C_Valid, bus.ADC_C_SOP, bus.ADC_C_EOP, bus.ADC_Interrupt},
              32'd0);
        check("rst_chan", {27'd0, bus.ADC_C_Channel}, 32'd0);
        check_reg("rst_adcs", 4'd0, 32'd0);
        RESETn = 1'b1;
        tick();

        // Three-cell sequence over mask bits 0,2,3.
        wr(4'd1, 32'h0D);
        push(5'd1, 1'b1, 1'b0);
        push(5'd3, 1'b0, 1'b0);
        push(5'd4, 1'b0, 1'b1);
        wr(4'd0, 32'h03);
        check("seq_valid_early", {31'd0, bus.ADC_C_Valid}, 32'd0);
        tick();
        check("seq_valid_n2", {31'd0, bus.ADC_C_Valid}, 32'd1);
        check_reg("seq_sc_clr_busy", 4'd0, 32'h41);
        tick();
        tick();
        tick();
        check("seq_valid_done", {31'd0, bus.ADC_C_Valid}, 32'd0);
        check_reg("seq_idle_adcs", 4'd0, 32'h01);
        check("seq_sb_empty", sb.size(), 32'd0);

        // Back-pressure on the second command.
        push(5'd1, 1'b1, 1'b0);
        push(5'd3, 1'b0, 1'b0);
        push(5'd4, 1'b0, 1'b1);
        wr(4'd0, 32'h03);
        tick();
        tick();
        bus.ADC_C_Ready = 1'b0;
        repeat (5) tick();
        check("bp_chan_held", {27'd0, bus.ADC_C_Channel}, 32'd3);
        bus.ADC_C_Ready = 1'b1;
        tick();
        tick();
        check("bp_valid_done", {31'd0, bus.ADC_C_Valid}, 32'd0);
        check("bp_sb_empty", sb.size(), 32'd0);

        // Trigger-started single-cell sequence with interrupt.
        wr(4'd1, 32'h40);
        wr(4'd0, 32'h0D);
        push(5'd17, 1'b1, 1'b1);
        bus.ADC_Trigger = 1'b1;
        tick();
        check("trig_valid", {31'd0, bus.ADC_C_Valid}, 32'd1);
        check("trig_chan", {27'd0, bus.ADC_C_Channel}, 32'd17);
        repeat (9) tick();
        bus.ADC_Trigger = 1'b0;
        check("trig_one_cmd", {31'd0, bus.ADC_C_Valid}, 32'd0);
        check("trig_sb_empty", sb.size(), 32'd0);
        resp(5'd17, 12'hABC, 1'b1);
        check_reg("trig_cell6", 4'd10, 32'hABC);
        check_reg("trig_new", 4'd2, 32'h40);
        check("trig_irq", {31'd0, bus.ADC_Interrupt}, 32'd1);
        check_reg("trig_adcs_if", 4'd0, 32'h1D);
        wr(4'd0, 32'h1D);
        check("trig_irq_clr", {31'd0, bus.ADC_Interrupt}, 32'd0);
        check_reg("trig_adcs_after", 4'd0, 32'h0D);
        wr(4'd0, 32'h00);

        // Continuous mode; EN cleared mid-sequence completes the sequence.
        wr(4'd1, 32'h03);
        repeat (4) begin
            push(5'd1, 1'b1, 1'b0);
            push(5'd2, 1'b0, 1'b1);
        end
        wr(4'd0, 32'h23);
        tick();
        check("cont_valid", {31'd0, bus.ADC_C_Valid}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("cont_nobubble", {31'd0, bus.ADC_C_Valid}, 32'd1);
        end
        wr(4'd0, 32'h20);
        check("cont_tail", {26'd0, bus.ADC_C_Valid, bus.ADC_C_Channel}, {26'd0, 1'b1, 5'd2});
        tick();
        check("cont_stop", {31'd0, bus.ADC_C_Valid}, 32'd0);
        check_reg("cont_adcs", 4'd0, 32'h20);
        check("cont_sb_empty", sb.size(), 32'd0);

        // New-data / overrun flags on cell 1 (channel 2).
        wr(4'd2, 32'h7F);
        wr(4'd3, 32'h7F);
        resp(5'd2, 12'h111, 1'b0);
        check_reg("ovr_new1", 4'd2, 32'h02);
        check_reg("ovr_none", 4'd3, 32'h00);
        resp(5'd2, 12'h222, 1'b1);
        check_reg("ovr_set", 4'd3, 32'h02);
        check_reg("ovr_cell1", 4'd5, 32'h222);
        check("ovr_no_irq", {31'd0, bus.ADC_Interrupt}, 32'd0);
        bus.write_addr   = 4'd2;
        bus.write_data   = 32'h02;
        bus.write_enable = 1'b1;
        resp(5'd2, 12'h333, 1'b0);
        bus.write_enable = 1'b0;
        check_reg("w1c_hw_wins", 4'd2, 32'h02);
        check_reg("w1c_cell1", 4'd5, 32'h333);
        wr(4'd2, 32'h02);
        check_reg("w1c_clear", 4'd2, 32'h00);
        check_reg("unmapped", 4'd15, 32'h00);

        // Asynchronous reset during ISSUE.
        wr(4'd1, 32'h01);
        bus.ADC_C_Ready = 1'b0;
        push(5'd1, 1'b1, 1'b1);
        wr(4'd0, 32'h03);
        tick();
        check("arst_pre", {26'd0, bus.ADC_C_Valid, bus.ADC_C_Channel}, {26'd0, 1'b1, 5'd1});
        #1;
        RESETn = 1'b0;
        #1;
        check("arst_cmd", {27'd0, bus.ADC_C_Valid, bus.ADC_C_SOP, bus.ADC_C_EOP, bus.ADC_Interrupt},
              32'd0);
        check("arst_chan", {27'd0, bus.ADC_C_Channel}, 32'd0);
        sb.delete();
        tick();
        RESETn = 1'b1;
        bus.ADC_C_Ready = 1'b1;
        check_reg("arst_adcs", 4'd0, 32'h00);
        check_reg("arst_mask", 4'd1, 32'h00);
        check_reg("arst_new", 4'd2, 32'h00);
        tick();
        check_reg("arst_ovr", 4'd3, 32'h00);
        check_reg("arst_cell1", 4'd5, 32'h00);
        check_reg("arst_cell6", 4'd10, 32'h00);
        tick();
        check("arst_idle", {31'd0, bus.ADC_C_Valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
